// File: rtl/sha_super_pipelined_w_sched.sv
// SHA-256 message-schedule stage for the super-pipelined round chain.
// Accepts one 512-bit padded block and streams W[0..ROUNDS-1] one word per
// clock. A new block can be accepted in the last-word cycle, so consecutive
// blocks stream without a bubble.
module sha_super_pipelined_w_sched #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] block_i,
    input  logic         block_valid_i,
    output logic         block_ready_o,
    output logic [31:0]  W_o,
    output logic         valid_o,
    output logic         newblock_o,
    output logic         last_o
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    // window[0] is the word currently on W_o; window[15] is the newest word
    logic [31:0] window [16];
    logic [5:0]  cnt;
    logic        busy;

    logic        at_last;
    logic        accept;
    logic [31:0] w_new;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Handshake decode; ready depends on registered state only
    always_comb begin
        at_last       = (cnt == LAST_IDX);
        block_ready_o = !busy || at_last;
        accept        = block_valid_i && block_ready_o;
    end

    // Next schedule word from the sliding window, W[t+16] for window[0] = W[t]
    always_comb begin
        w_new = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
    end

    // Window, index and busy flag: load on accept, shift while streaming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                window[i] <= '0;
            end
        end else if (accept) begin
            busy <= 1'b1;
            cnt  <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                window[i] <= block_i[511 - 32*i -: 32];
            end
        end else if (busy) begin
            if (!at_last) begin
                cnt <= cnt + 6'd1;
                for (int unsigned i = 0; i < 15; i++) begin
                    window[i] <= window[i + 1];
                end
                window[15] <= w_new;
            end else begin
                busy <= 1'b0;
            end
        end
    end

    // Output decode from the registered state
    always_comb begin
        W_o        = window[0];
        valid_o    = busy;
        newblock_o = busy && (cnt == 6'd0);
        last_o     = busy && at_last;
    end

endmodule

// File: tb/tb_sha_super_pipelined_w_sched.sv
// Directed bench for the SHA-256 message-schedule stage (ROUNDS=64 and 16).
module tb_sha_super_pipelined_w_sched;

    logic         clk;
    logic         rst;
    logic [511:0] blk;
    logic         bv;
    logic         ready;
    logic [31:0]  w64;
    logic         vo, nbo, lo;

    logic [511:0] b16;
    logic         v16;
    logic         ready16;
    logic [31:0]  w16;
    logic         vo16, nbo16, lo16;

    int unsigned vectors = 0;
    int unsigned errs    = 0;

    logic [31:0] ew  [64];
    logic [31:0] cap [64];

    bit          cnt_en = 1'b0;
    int unsigned vcnt   = 0;
    int unsigned acnt   = 0;

    sha_super_pipelined_w_sched #(.ROUNDS(64)) dut (
        .clk(clk), .rst(rst), .block_i(blk), .block_valid_i(bv),
        .block_ready_o(ready), .W_o(w64), .valid_o(vo),
        .newblock_o(nbo), .last_o(lo)
    );

    sha_super_pipelined_w_sched #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst(rst), .block_i(b16), .block_valid_i(v16),
        .block_ready_o(ready16), .W_o(w16), .valid_o(vo16),
        .newblock_o(nbo16), .last_o(lo16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count live words and accepted blocks during the random phase
    always @(negedge clk) begin
        if (cnt_en) begin
            if (vo) vcnt++;
            if (bv && ready) acnt++;
        end
    end

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Reference schedule via the plain W[t] recurrence
    task automatic expand(input logic [511:0] b);
        for (int i = 0; i < 64; i++) begin
            if (i < 16) ew[i] = b[511 - 32*i -: 32];
            else        ew[i] = s1(ew[i-2]) + ew[i-7] + s0(ew[i-15]) + ew[i-16];
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Check n words of the 64-round stream starting in the current cycle;
    // at word raise_at, present nb with block_valid_i high
    task automatic stream(input int n, input int raise_at, input logic [511:0] nb);
        for (int t = 0; t < n; t++) begin
            if (t == raise_at) begin
                blk = nb;
                bv  = 1'b1;
            end
            cap[t] = w64;
            chk($sformatf("w[%0d]", t), w64, ew[t]);
            chk($sformatf("valid[%0d]", t), 32'(vo), 32'd1);
            chk($sformatf("newblock[%0d]", t), 32'(nbo), 32'(t == 0));
            chk($sformatf("last[%0d]", t), 32'(lo), 32'(t == 63));
            chk($sformatf("ready[%0d]", t), 32'(ready), 32'(t == 63));
            if (t < n - 1) tick();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(vo), 32'd0);
        chk({tag, "_newblock"}, 32'(nbo), 32'd0);
        chk({tag, "_last"}, 32'(lo), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    logic [511:0] abc, blk_b, blk_c, blk_d, blk_e, cur, nxt, x16, y16;
    int unsigned  gap;

    initial begin
        abc   = {32'h61626380, 448'h0, 32'h00000018};
        blk_b = {32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
                 32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0,
                 32'hDEADBEEF, 32'hCAFEBABE, 32'h0F0F0F0F, 32'hF0F0F0F0,
                 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 32'h7FFFFFFF};
        blk_c = {16{32'hFFFFFFFF}};
        blk_d = {16{32'h01234567}};
        blk_e = {16{32'h89ABCDEF}};
        for (int i = 0; i < 16; i++) begin
            x16[511 - 32*i -: 32] = 32'hA5000000 + 32'(i);
            y16[511 - 32*i -: 32] = 32'h3C000000 + 32'(i * 3);
        end

        // Reset state
        rst = 1'b1; bv = 1'b0; blk = '0; v16 = 1'b0; b16 = '0;
        #3;
        chk("rst_w", w64, 32'h0);
        chk_idle("rst");
        @(posedge clk);
        #1 rst = 1'b0;

        // "abc" block, single
        blk = abc; bv = 1'b1;
        tick();
        bv = 1'b0;
        expand(abc);
        stream(64, -1, '0);
        chk("abc_w16_hand", cap[16], 32'h61626380);
        chk("abc_w17_hand", cap[17], 32'h000F0000);
        chk("abc_w15_hand", cap[15], 32'h00000018);
        tick();
        chk_idle("abc_end");
        chk("abc_hold_w", w64, ew[63]);

        // Back to back with valid held high
        blk = abc; bv = 1'b1;
        tick();
        stream(64, 63, blk_b);
        tick();
        bv = 1'b0;
        expand(blk_b);
        stream(64, -1, '0);
        tick();
        chk_idle("b2b_end");

        // Valid raised at t=10: held off until the last-word edge
        blk = blk_c; bv = 1'b1;
        tick();
        bv = 1'b0;
        expand(blk_c);
        stream(64, 10, blk_d);
        tick();
        bv = 1'b0;
        expand(blk_d);
        stream(64, -1, '0);
        tick();
        chk_idle("hold_end");

        // Reset pulsed at t=30
        blk = blk_e; bv = 1'b1;
        tick();
        bv = 1'b0;
        expand(blk_e);
        stream(31, -1, '0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_w", w64, 32'h0);
        chk_idle("midrst");
        #1 rst = 1'b0;
        blk = abc; bv = 1'b1;
        tick();
        bv = 1'b0;
        expand(abc);
        stream(64, -1, '0);
        tick();
        chk_idle("postrst_end");

        // ROUNDS=16 build: words equal M[0..15], back-to-back reload
        b16 = x16; v16 = 1'b1;
        tick();
        v16 = 1'b0;
        for (int t = 0; t < 16; t++) begin
            if (t == 15) begin b16 = y16; v16 = 1'b1; end
            chk($sformatf("r16x_w[%0d]", t), w16, 32'hA5000000 + 32'(t));
            chk($sformatf("r16x_nb[%0d]", t), 32'(nbo16), 32'(t == 0));
            chk($sformatf("r16x_last[%0d]", t), 32'(lo16), 32'(t == 15));
            tick();
        end
        v16 = 1'b0;
        for (int t = 0; t < 16; t++) begin
            chk($sformatf("r16y_w[%0d]", t), w16, 32'h3C000000 + 32'(t * 3));
            chk($sformatf("r16y_valid[%0d]", t), 32'(vo16), 32'd1);
            chk($sformatf("r16y_last[%0d]", t), 32'(lo16), 32'(t == 15));
            tick();
        end
        chk("r16_end_valid", 32'(vo16), 32'd0);
        chk("r16_end_ready", 32'(ready16), 32'd1);

        // Random blocks with random gaps (including zero-gap reloads)
        cnt_en = 1'b1;
        cur = rand512();
        blk = cur; bv = 1'b1;
        tick();
        bv = 1'b0;
        for (int k = 0; k < 60; k++) begin
            gap = (k == 59) ? 1 : $urandom_range(0, 2);
            nxt = rand512();
            expand(cur);
            stream(64, (gap == 0) ? 63 : -1, nxt);
            tick();
            bv = 1'b0;
            for (int g = 0; g < int'(gap); g++) begin
                chk($sformatf("rnd_gap_valid[%0d]", k), 32'(vo), 32'd0);
                if (g == int'(gap) - 1 && k != 59) begin
                    blk = nxt; bv = 1'b1;
                end
                tick();
            end
            bv = 1'b0;
            cur = nxt;
        end
        cnt_en = 1'b0;
        chk("rnd_accepts", acnt, 32'd60);
        chk("rnd_valid_cycles", vcnt, 32'(64 * acnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs + 1);
        $fatal(1, "timeout");
    end

endmodule
